pcieifc_fifo_wptr_full: RTL and testbench
=========================================

Name: pcieifc_fifo_wptr_full

Overview:
Write-domain pointer and status generator for the PCIe interface async FIFO. It sits directly upstream of the FIFO dual-port memory and drives that memory's write address and full flag. It keeps the binary and Gray write pointers and synchronises the read-domain Gray pointer into wclk. From these it produces registered full, almost-full, level and overflow status for the write-side client.

Parameters:
ADDRSIZE, 4, memory address bits; DEPTH = 1<<ADDRSIZE.
AFULL_THRESH, 2, walmost_full asserts when free entries <= AFULL_THRESH; legal range 1..DEPTH-1.
SYNC_STAGES, 2, flop stages on rptr crossing into wclk; minimum 2.

Ports:
wclk  in  1  write clock
wrst_n  in  1  async active-low reset
winc  in  1  write request from client; also drives memory write enable (wclken)
rptr  in  ADDRSIZE+1  read-domain Gray pointer, registered in rclk domain
waddr  out  ADDRSIZE  memory write address
wptr  out  ADDRSIZE+1  registered Gray write pointer, to read-side synchroniser
wfull  out  1  FIFO full; drives memory wfull
walmost_full  out  1  free entries <= AFULL_THRESH
wlevel  out  ADDRSIZE+1  occupied entries as seen from write domain, 0..DEPTH
woverflow  out  1  one-cycle pulse: winc while wfull

Behaviour:
- Reset wrst_n: asynchronous, active-low; clock wclk. All flops reset to 0: wbin, wptr, sync chain, wfull, walmost_full, wlevel, woverflow. waddr=0 after reset.
- wq2_rptr = rptr after SYNC_STAGES wclk flops. No logic between stages. The first stage gets no combinational input other than rptr.
- Write accept: wacc = winc & ~wfull. Full is evaluated on the registered wfull, so no combinational path from rptr to wacc.
- wbinnext = wbin + wacc, computed modulo 2^(ADDRSIZE+1). wgraynext = (wbinnext>>1) ^ wbinnext. Both wbin and wptr are registered each cycle.
- waddr = wbin[ADDRSIZE-1:0], straight from the register. The memory writes mem[waddr] on the same edge that wbin advances.
- wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}). wfull is registered.
  - Assertion happens the same edge the DEPTH-th write is accepted.
  - Deassertion happens SYNC_STAGES+1 wclk edges after rptr changes (pessimistic).
- rq2_bin = Gray-to-binary of wq2_rptr, computed as an XOR prefix from the MSB.
- wlevel_next = wbinnext - rq2_bin, modulo 2^(ADDRSIZE+1). Registered, so it always lies in 0..DEPTH.
- walmost_full_next = (wlevel_next >= DEPTH - AFULL_THRESH). Registered, and consistent with wfull on the same edge.
- woverflow = registered (winc & wfull). The write is dropped: no pointer change and no memory write.
- Wrap: pointer MSB toggles every DEPTH writes, and Gray changes exactly one bit per increment.
- Simultaneous write and read-pointer advance: both enter wlevel_next on the same cycle. This never falsely asserts wfull.
- Reset mid-operation: the state clears immediately. The read side must be reset in the same window. A pointer mismatch between domains across a one-sided reset is out of scope.
- rptr must be Gray and change at most one bit per rclk. The block does not check this.

Decomposition:
- Shared package pcieifc_fifo_pkg holds:
  - function gray2bin(ADDRSIZE+1)
  - function bin2gray(ADDRSIZE+1)
  - localparam PTRW = ADDRSIZE+1
  - These are reused by the matching read-side rptr/empty block.
- One sub-module: pcieifc_sync_ff, a parameterised WIDTH/STAGES synchroniser with async active-low reset to 0. It is instantiated once for rptr.

Test Plan:
- Reset then idle, ADDRSIZE=4, rptr=0 -> waddr=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
- 16 back-to-back winc, rptr held 0:
  - waddr steps 0..15.
  - walmost_full rises with the edge that accepts write 14 (wlevel=14).
  - wfull rises with write 16 (wlevel=16, wptr=5'b11000).
- winc held 3 more cycles while full -> woverflow pulses each cycle, wbin/wptr/waddr unchanged.
- From full, rptr steps Gray 0->1 -> wfull stays 1 for SYNC_STAGES cycles, clears on the 3rd edge, wlevel=15.
- Continuous write/read over 40 entries with rptr trailing by 3 -> wptr wraps past 5'b10000 back through 0 with one-bit Gray changes. wlevel stays 3, wfull never asserts.
- wrst_n asserted asynchronously mid-burst at wlevel=9 -> all outputs 0 before the next wclk edge. Writes resume at waddr=0 after release.

Source files
------------

// File: rtl/pcieifc_fifo_pkg.sv
// Shared definitions for the PCIe interface async FIFO pointer blocks.
// Holds the pointer width and the Gray/binary conversions used by both the
// write-side (wptr/full) and read-side (rptr/empty) pointer generators.
package pcieifc_fifo_pkg;

    localparam int unsigned FIFO_ADDRSIZE = 4;
    // One extra bit beyond the address distinguishes full from empty.
    localparam int unsigned PTRW = FIFO_ADDRSIZE + 1;

    function automatic logic [PTRW-1:0] bin2gray(input logic [PTRW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // XOR prefix from the MSB down.
    function automatic logic [PTRW-1:0] gray2bin(input logic [PTRW-1:0] g);
        logic [PTRW-1:0] b;
        b[PTRW-1] = g[PTRW-1];
        for (int i = int'(PTRW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pcieifc_sync_ff.sv
// Multi-flop synchroniser for bringing a (Gray-coded) bus into a new clock
// domain. No logic between stages; all stages reset to 0.
// Ports:
//   clk    destination-domain clock
//   rst_n  async active-low reset
//   d      input from the foreign domain
//   q      synchronised output (last stage)
module pcieifc_sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/pcieifc_fifo_wptr_full.sv
// Write-domain pointer and status generator for the PCIe interface async FIFO.
// Keeps binary and Gray write pointers, synchronises the read Gray pointer
// into wclk and produces registered full / almost-full / level / overflow.
// ADDRSIZE must match pcieifc_fifo_pkg::FIFO_ADDRSIZE (shared pointer helpers).
// Ports:
//   wclk          write clock
//   wrst_n        async active-low reset
//   winc          write request (also the memory write enable)
//   rptr          read-domain Gray pointer (registered in rclk domain)
//   waddr         memory write address
//   wptr          registered Gray write pointer, to read-side synchroniser
//   wfull         FIFO full
//   walmost_full  free entries <= AFULL_THRESH
//   wlevel        occupied entries seen from the write domain, 0..DEPTH
//   woverflow     one-cycle pulse: winc while wfull (write dropped)
module pcieifc_fifo_wptr_full
    import pcieifc_fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = FIFO_ADDRSIZE,
    parameter int unsigned AFULL_THRESH = 2,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] AFULL_LEVEL = (ADDRSIZE + 1)'(DEPTH - AFULL_THRESH);

    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] rq2_bin;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] wlevel_next;
    logic              wacc;
    logic              wfull_next;
    logic              walmost_full_next;

    pcieifc_sync_ff #(
        .WIDTH  (ADDRSIZE + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync_rptr (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr),
        .q     (wq2_rptr)
    );

    // Registered wfull gates acceptance, so rptr has no combinational path here.
    assign wacc      = winc & ~wfull;
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wacc};
    assign wgraynext = bin2gray(wbinnext);
    assign rq2_bin   = gray2bin(wq2_rptr);

    // Full when write Gray equals read Gray with the top two bits inverted.
    assign wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

    assign wlevel_next       = wbinnext - rq2_bin;
    assign walmost_full_next = (wlevel_next >= AFULL_LEVEL);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= wfull_next;
            walmost_full <= walmost_full_next;
            wlevel       <= wlevel_next;
            woverflow    <= winc & wfull;
        end
    end

    assign waddr = wbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_pcieifc_fifo_wptr_full.sv
// Directed bench for pcieifc_fifo_wptr_full (ADDRSIZE=4, AFULL_THRESH=2,
// SYNC_STAGES=2). Outputs are sampled 1 time unit after each rising edge.
module tb_pcieifc_fifo_wptr_full;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] rptr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int n_cmp;
    int n_err;

    pcieifc_fifo_wptr_full #(
        .ADDRSIZE     (4),
        .AFULL_THRESH (2),
        .SYNC_STAGES  (2)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr         (rptr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".waddr"}, 32'(waddr), 32'd0);
        check({tag, ".wptr"}, 32'(wptr), 32'd0);
        check({tag, ".wfull"}, 32'(wfull), 32'd0);
        check({tag, ".walmost_full"}, 32'(walmost_full), 32'd0);
        check({tag, ".wlevel"}, 32'(wlevel), 32'd0);
        check({tag, ".woverflow"}, 32'(woverflow), 32'd0);
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [4:0] wb;
        n_cmp  = 0;
        n_err  = 0;
        wrst_n = 1'b0;
        winc   = 1'b0;
        rptr   = 5'd0;

        // Reset then idle.
        #12;
        check_all_zero("reset");
        @(negedge wclk);
        wrst_n = 1'b1;
        step();
        step();
        check_all_zero("idle");

        // 16 back-to-back writes, rptr held at 0.
        winc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("fill%0d.waddr", k), 32'(waddr), 32'(k % 16));
            check($sformatf("fill%0d.wlevel", k), 32'(wlevel), 32'(k));
            check($sformatf("fill%0d.walmost_full", k), 32'(walmost_full), 32'(k >= 14));
            check($sformatf("fill%0d.wfull", k), 32'(wfull), 32'(k == 16));
        end
        check("fill16.wptr", 32'(wptr), 32'h18);

        // Keep writing while full: overflow pulses, pointers frozen.
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("ovf%0d.woverflow", k), 32'(woverflow), 32'd1);
            check($sformatf("ovf%0d.wptr", k), 32'(wptr), 32'h18);
            check($sformatf("ovf%0d.waddr", k), 32'(waddr), 32'd0);
            check($sformatf("ovf%0d.wlevel", k), 32'(wlevel), 32'd16);
        end
        winc = 1'b0;
        step();
        check("ovf_end.woverflow", 32'(woverflow), 32'd0);

        // One read: full clears on the third edge after rptr moves.
        rptr = 5'b00001;
        step();
        check("drain1.wfull", 32'(wfull), 32'd1);
        step();
        check("drain2.wfull", 32'(wfull), 32'd1);
        step();
        check("drain3.wfull", 32'(wfull), 32'd0);
        check("drain3.wlevel", 32'(wlevel), 32'd15);
        check("drain3.walmost_full", 32'(walmost_full), 32'd1);

        // Streaming with the reader trailing: level settles at 3, pointer wraps.
        wrst_n = 1'b0;
        rptr   = 5'd0;
        #1;
        wrst_n = 1'b1;
        winc   = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("warm.wlevel", 32'(wlevel), 32'd3);
        for (int i = 0; i < 40; i++) begin
            wb   = 5'(3 + i);
            rptr = gray(wb);
            step();
            wb = 5'(4 + i);
            check($sformatf("stream%0d.wptr", i), 32'(wptr), 32'(gray(wb)));
            check($sformatf("stream%0d.waddr", i), 32'(waddr), 32'(wb[3:0]));
            check($sformatf("stream%0d.wfull", i), 32'(wfull), 32'd0);
            if (i >= 2) begin
                check($sformatf("stream%0d.wlevel", i), 32'(wlevel), 32'd3);
            end
        end
        winc = 1'b0;

        // Asynchronous reset mid-burst.
        wrst_n = 1'b0;
        rptr   = 5'd0;
        #1;
        wrst_n = 1'b1;
        winc   = 1'b1;
        for (int k = 0; k < 9; k++) step();
        check("burst.wlevel", 32'(wlevel), 32'd9);
        #2;
        wrst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge wclk);
        wrst_n = 1'b1;
        #1;
        check("resume0.waddr", 32'(waddr), 32'd0);
        step();
        check("resume1.waddr", 32'(waddr), 32'd1);
        check("resume1.wlevel", 32'(wlevel), 32'd1);
        winc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
